// File: rtl/fdiv_iter.sv
// Iterative IEEE-754 single-precision divider for the EX stage: restoring radix-2,
// one quotient bit per cycle, round-to-nearest-even, subnormals flushed to zero.
module fdiv_iter #(
   parameter int unsigned Iter = 26
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   input  logic        advance_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] result_o,
   output logic [4:0]  fflags_o
);

   localparam logic [31:0] QNaN   = 32'h7FC0_0000;
   localparam logic [4:0]  FlagNv = 5'b10000;
   localparam logic [4:0]  FlagDz = 5'b01000;
   localparam logic [4:0]  FlagOf = 5'b00100;
   localparam logic [4:0]  FlagUf = 5'b00010;
   localparam logic [4:0]  FlagNx = 5'b00001;

   typedef enum logic [1:0] {StIdle, StDiv, StRound, StDone} state_e;

   state_e            state_q;
   logic [24:0]       rem_q;
   logic [23:0]       div_q;
   logic [Iter-1:0]   q_q;
   logic [4:0]        cnt_q;
   logic signed [9:0] exp_q;
   logic              sign_q;
   logic              done_q;
   logic [31:0]       result_q;
   logic [4:0]        fflags_q;

   // Operand unpack and special-case classification
   logic [7:0]        ea, eb;
   logic [22:0]       fa, fb;
   logic              sign;
   logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic signed [9:0] exp_init;

   assign ea       = op_a_i[30:23];
   assign eb       = op_b_i[30:23];
   assign fa       = op_a_i[22:0];
   assign fb       = op_b_i[22:0];
   assign sign     = op_a_i[31] ^ op_b_i[31];
   assign a_nan    = (ea == 8'hff) && (fa != 23'h0);
   assign b_nan    = (eb == 8'hff) && (fb != 23'h0);
   assign a_inf    = (ea == 8'hff) && (fa == 23'h0);
   assign b_inf    = (eb == 8'hff) && (fb == 23'h0);
   assign a_zero   = (ea == 8'h00);
   assign b_zero   = (eb == 8'h00);
   assign exp_init = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;

   logic        spec_hit;
   logic [31:0] spec_res;
   logic [4:0]  spec_flags;

   always_comb begin
      spec_hit   = 1'b1;
      spec_res   = 32'h0;
      spec_flags = 5'h0;
      if (a_nan || b_nan) begin
         spec_res   = QNaN;
         spec_flags = ((a_nan && !fa[22]) || (b_nan && !fb[22])) ? FlagNv : 5'h0;
      end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
         spec_res   = QNaN;
         spec_flags = FlagNv;
      end else if (a_inf) begin
         spec_res = {sign, 8'hff, 23'h0};
      end else if (b_inf) begin
         spec_res = {sign, 31'h0};
      end else if (b_zero) begin
         spec_res   = {sign, 8'hff, 23'h0};
         spec_flags = FlagDz;
      end else if (a_zero) begin
         spec_res = {sign, 31'h0};
      end else begin
         spec_hit = 1'b0;
      end
   end

   // Restoring divide step
   logic              rem_ge;
   logic [24:0]       rem_sub;
   logic [24:0]       rem_next;
   logic [Iter-1:0]   q_next;

   assign rem_ge   = rem_q >= {1'b0, div_q};
   assign rem_sub  = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;
   assign rem_next = rem_sub << 1;
   assign q_next   = {q_q[Iter-2:0], rem_ge};

   // Normalize, round and range-check the finished quotient
   logic              norm;
   logic [22:0]       frac_pre;
   logic              guard, sticky, round_up;
   logic [23:0]       frac_inc;
   logic signed [9:0] exp_norm, exp_rnd;
   logic [31:0]       rnd_res;
   logic [4:0]        rnd_flags;

   assign norm     = q_q[Iter-1];
   assign frac_pre = norm ? q_q[Iter-2:2] : q_q[Iter-3:1];
   assign guard    = norm ? q_q[1] : q_q[0];
   assign sticky   = (norm & q_q[0]) | (rem_q != 25'h0);
   assign round_up = guard & (sticky | frac_pre[0]);
   assign exp_norm = norm ? exp_q : (exp_q - 10'sd1);
   // A fraction carry-out means the mantissa rolled over to 1.0 of the next binade
   assign frac_inc = {1'b0, frac_pre} + {23'h0, round_up};
   assign exp_rnd  = exp_norm + (frac_inc[23] ? 10'sd1 : 10'sd0);

   always_comb begin
      rnd_res   = {sign_q, exp_rnd[7:0], frac_inc[22:0]};
      rnd_flags = (guard | sticky) ? FlagNx : 5'h0;
      if (exp_rnd >= 10'sd255) begin
         rnd_res   = {sign_q, 8'hff, 23'h0};
         rnd_flags = FlagOf | FlagNx;
      end else if (exp_rnd <= 10'sd0) begin
         rnd_res   = {sign_q, 31'h0};
         rnd_flags = FlagUf | FlagNx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         rem_q    <= '0;
         div_q    <= '0;
         q_q      <= '0;
         cnt_q    <= '0;
         exp_q    <= '0;
         sign_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         fflags_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  sign_q <= sign;
                  if (spec_hit) begin
                     result_q <= spec_res;
                     fflags_q <= spec_flags;
                     done_q   <= 1'b1;
                     state_q  <= StDone;
                  end else begin
                     rem_q   <= {2'b01, fa};
                     div_q   <= {1'b1, fb};
                     q_q     <= '0;
                     cnt_q   <= '0;
                     exp_q   <= exp_init;
                     state_q <= StDiv;
                  end
               end
            end
            StDiv: begin
               rem_q <= rem_next;
               q_q   <= q_next;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'(Iter - 1)) begin
                  state_q <= StRound;
               end
            end
            StRound: begin
               result_q <= rnd_res;
               fflags_q <= rnd_flags;
               exp_q    <= exp_rnd;
               done_q   <= 1'b1;
               state_q  <= StDone;
            end
            StDone: begin
               if (advance_i) begin
                  done_q  <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy_o   = start_i & ~done_q;
   assign done_o   = done_q;
   assign result_o = result_q;
   assign fflags_o = fflags_q;

endmodule

// File: tb/tb_fdiv_iter.sv
// Bench for fdiv_iter: directed scenarios plus random operands checked against an
// integer-division reference of the divide/round rules.
module tb_fdiv_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] op_a, op_b;
   logic        advance;
   logic        busy, done;
   logic [31:0] result;
   logic [4:0]  fflags;

   int checks = 0;
   int errors = 0;

   fdiv_iter dut (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start),
      .op_a_i    (op_a),
      .op_b_i    (op_b),
      .advance_i (advance),
      .busy_o    (busy),
      .done_o    (done),
      .result_o  (result),
      .fflags_o  (fflags)
   );

   always #5 clk = ~clk;

   // Reference: long-division quotient floor(ma*2^25/mb) with remainder, then the rounding rules
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output logic [4:0] flg,
                                 output bit special);
      logic s;
      int   ea, eb, e;
      logic [22:0] fa, fb;
      bit   an, bn, ai, bi, az, bz, g, st;
      longint unsigned num, den, q, r, mant;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      fa = a[22:0];
      fb = b[22:0];
      an = (ea == 255) && (fa != 0);
      bn = (eb == 255) && (fb != 0);
      ai = (ea == 255) && (fa == 0);
      bi = (eb == 255) && (fb == 0);
      az = (ea == 0);
      bz = (eb == 0);
      special = 1'b1;
      flg = 5'h00;
      if (an || bn) begin
         res = 32'h7FC00000;
         if ((an && !fa[22]) || (bn && !fb[22])) flg = 5'h10;
      end else if ((ai && bi) || (az && bz)) begin
         res = 32'h7FC00000;
         flg = 5'h10;
      end else if (ai) begin
         res = {s, 8'hff, 23'h0};
      end else if (bi) begin
         res = {s, 31'h0};
      end else if (bz) begin
         res = {s, 8'hff, 23'h0};
         flg = 5'h08;
      end else if (az) begin
         res = {s, 31'h0};
      end else begin
         special = 1'b0;
         num = (longint'(fa) + 64'd8388608) << 25;
         den = longint'(fb) + 64'd8388608;
         q = num / den;
         r = num % den;
         e = ea - eb + 127;
         if (q >= 64'd33554432) begin
            mant = q >> 2;
            g    = q[1];
            st   = q[0] || (r != 0);
         end else begin
            mant = q >> 1;
            g    = q[0];
            st   = (r != 0);
            e    = e - 1;
         end
         if (g && (st || mant[0])) mant = mant + 1;
         if (mant == 64'd16777216) begin
            mant = 64'd8388608;
            e    = e + 1;
         end
         flg = (g || st) ? 5'h01 : 5'h00;
         if (e >= 255) begin
            res = {s, 8'hff, 23'h0};
            flg = 5'h05;
         end else if (e <= 0) begin
            res = {s, 31'h0};
            flg = 5'h03;
         end else begin
            res = {s, e[7:0], mant[22:0]};
         end
      end
   endfunction

   // Drives one divide from IDLE and reports what was observed; the callers judge it
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                         input bit keep_start, output logic [31:0] res,
                         output logic [4:0] flg, output int lat, output int busy_bad,
                         output logic busy_at_done, output int unstable);
      op_a = a;
      op_b = b;
      start = 1'b1;
      advance = (hold == 0);
      lat = 0;
      busy_bad = 0;
      unstable = 0;
      #1;
      if (busy !== 1'b1) busy_bad++;
      while (done !== 1'b1 && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1) begin
            op_a = $urandom;
            op_b = $urandom;
         end
         if (done !== 1'b1 && busy !== 1'b1) busy_bad++;
      end
      res = result;
      flg = fflags;
      busy_at_done = busy;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         if (result !== res || fflags !== flg || done !== 1'b1) unstable++;
      end
      advance = 1'b1;
      @(posedge clk);
      #1;
      advance = 1'b0;
      if (!keep_start) start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      advance = 1'b0;
      op_a = '0;
      op_b = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: done=%b busy=%b, expected 0 0", done, busy);
      end
      checks++;
      if (result !== 32'h0 || fflags !== 5'h0) begin
         errors++;
         $display("FAIL reset_data: result=%h fflags=%h, expected 0 0", result, fflags);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_exact();
      logic [31:0] r; logic [4:0] f; int lat, bb, us; logic bd;
      run_op(32'h40C00000, 32'h40000000, 0, 0, r, f, lat, bb, bd, us);
      checks++;
      if (r !== 32'h40400000 || f !== 5'h00) begin
         errors++;
         $display("FAIL exact: got %h/%h expected 40400000/00", r, f);
      end
      checks++;
      if (lat !== 28) begin
         errors++;
         $display("FAIL exact_latency: done in cycle %0d expected 28", lat);
      end
      checks++;
      if (bb !== 0 || bd !== 1'b0) begin
         errors++;
         $display("FAIL exact_busy: %0d cycles low before done, busy at done=%b expected 0,0",
                  bb, bd);
      end
   endtask

   task automatic test_inexact();
      logic [31:0] r; logic [4:0] f; int lat, bb, us; logic bd;
      run_op(32'h3F800000, 32'h40400000, 0, 0, r, f, lat, bb, bd, us);
      checks++;
      if (r !== 32'h3EAAAAAB || f !== 5'h01) begin
         errors++;
         $display("FAIL inexact: got %h/%h expected 3eaaaaab/01", r, f);
      end
   endtask

   task automatic test_specials();
      logic [31:0] ta [3] = '{32'h3F800000, 32'h00000000, 32'h7F800001};
      logic [31:0] tb [3] = '{32'h00000000, 32'h00000000, 32'h3F800000};
      logic [31:0] tr [3] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000};
      logic [4:0]  tf [3] = '{5'h08, 5'h10, 5'h10};
      logic [31:0] r; logic [4:0] f; int lat, bb, us; logic bd;
      for (int i = 0; i < 3; i++) begin
         run_op(ta[i], tb[i], 0, 0, r, f, lat, bb, bd, us);
         checks++;
         if (r !== tr[i] || f !== tf[i] || lat !== 1) begin
            errors++;
            $display("FAIL special%0d: got %h/%h in cycle %0d expected %h/%h in cycle 1",
                     i, r, f, lat, tr[i], tf[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r; logic [4:0] f; int lat, bb, us; logic bd;
      op_a = 32'h40C00000;
      op_b = 32'h40000000;
      start = 1'b1;
      advance = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (done !== 1'b0 || result !== 32'h0 || fflags !== 5'h0) begin
         errors++;
         $display("FAIL reset_mid: done=%b result=%h fflags=%h expected 0/0/0",
                  done, result, fflags);
      end
      start = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      run_op(32'h3F800000, 32'h40400000, 0, 0, r, f, lat, bb, bd, us);
      checks++;
      if (r !== 32'h3EAAAAAB || f !== 5'h01 || lat !== 28) begin
         errors++;
         $display("FAIL after_reset: got %h/%h in cycle %0d expected 3eaaaaab/01 in 28",
                  r, f, lat);
      end
   endtask

   task automatic test_range();
      logic [31:0] r; logic [4:0] f; int lat, bb, us; logic bd;
      run_op(32'h7F7FFFFF, 32'h3F000000, 0, 0, r, f, lat, bb, bd, us);
      checks++;
      if (r !== 32'h7F800000 || f !== 5'h05) begin
         errors++;
         $display("FAIL overflow: got %h/%h expected 7f800000/05", r, f);
      end
      run_op(32'h00800000, 32'h40000000, 0, 0, r, f, lat, bb, bd, us);
      checks++;
      if (r !== 32'h00000000 || f !== 5'h03) begin
         errors++;
         $display("FAIL underflow: got %h/%h expected 00000000/03", r, f);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r; logic [4:0] f; int lat, bb, us; logic bd;
      run_op(32'h3F800000, 32'h40400000, 3, 1, r, f, lat, bb, bd, us);
      checks++;
      if (us !== 0 || r !== 32'h3EAAAAAB) begin
         errors++;
         $display("FAIL hold: %0d unstable cycles result %h expected 0 and 3eaaaaab", us, r);
      end
      run_op(32'h40C00000, 32'h40000000, 0, 0, r, f, lat, bb, bd, us);
      checks++;
      if (r !== 32'h40400000 || f !== 5'h00 || lat !== 28 || bb !== 0) begin
         errors++;
         $display("FAIL back_to_back: got %h/%h cycle %0d busy_gaps %0d expected 40400000/00 28 0",
                  r, f, lat, bb);
      end
   endtask

   function automatic logic [31:0] rand_op();
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 11))
         0: v[30:23] = 8'h00;
         1: v[30:0] = {8'hff, 23'h0};
         2: begin
            v[30:23] = 8'hff;
            if (v[22:0] == 23'h0) v[0] = 1'b1;
         end
         3: v[30:23] = 8'($urandom_range(1, 254));
         4: v[22:0] = 23'h7fffff;
         default: v[30:23] = 8'($urandom_range(70, 184));
      endcase
      if (v[30:23] == 8'h00 && $urandom_range(0, 1) == 1) v[22:0] = 23'h0;
      return v;
   endfunction

   task automatic test_random();
      logic [31:0] a, b, r, er; logic [4:0] f, ef; int lat, bb, us; logic bd; bit sp;
      int hold; bit keep;
      for (int n = 0; n < 80; n++) begin
         a = rand_op();
         b = ($urandom_range(0, 3) == 0) ? a : rand_op();
         model(a, b, er, ef, sp);
         hold = $urandom_range(0, 2);
         keep = ($urandom_range(0, 1) == 1);
         run_op(a, b, hold, keep, r, f, lat, bb, bd, us);
         checks++;
         if (r !== er || f !== ef || lat !== (sp ? 1 : 28) || bb !== 0 || us !== 0) begin
            errors++;
            $display("FAIL random%0d %h/%h: got %h/%h cycle %0d expected %h/%h cycle %0d",
                     n, a, b, r, f, lat, er, ef, sp ? 1 : 28);
         end
      end
      start = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_exact();
      test_inexact();
      test_specials();
      test_reset_mid();
      test_range();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fdiv_iter.md
# fdiv_iter

Iterative single-precision floating-point divider in the EX stage of the RV32IF pipeline. It consumes the `frs1`/`frs2` operands that the ID/EX pipeline register presents for an `FDIV.S`. It raises `busy` so the hazard unit freezes the front of the pipeline. It holds a rounded IEEE-754 result and its `fflags` until the pipeline advances EX→MEM. Simplified numerics:

- Round-to-nearest-even only.
- Subnormal inputs and outputs are flushed to zero.

## Interface
- `ITER`, default 26: quotient bits generated, one per cycle. This is 24 significand bits plus guard plus sticky seed. It is fixed and not meant to be overridden.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: EX holds a valid, unflushed `FDIV.S`. Level signal, held high while `busy`.
- `op_a` in 32: dividend, the `frs1` value from the ID/EX register.
- `op_b` in 32: divisor, the `frs2` value from the ID/EX register.
- `advance` in 1: the EX→MEM register loads this cycle. High means no IM/DM stall and no `busy`.
- `busy` out 1: stall request to the hazard unit. Defined as `start & ~done`.
- `done` out 1: `result` and `fflags` are valid.
- `result` out 32: quotient.
- `fflags` out 5: exception flags {NV, DZ, OF, UF, NX}, bits 4..0.

## Operation
States are IDLE, DIV, ROUND, DONE.

**IDLE.** When `start` is high:
- Unpack both operands.
- Compute `sign = a[31]^b[31]`.
- Treat an exponent field of 0 as zero (FTZ).
- If the operands form a special case, load the special result and go to DONE. Otherwise load the state below and go to DIV:
  - `rem = {1, a_frac}`, `div = {1, b_frac}`, `q = 0`, `cnt = 0`.
  - `exp = ea - eb + 127`, computed as a 10-bit signed value.

**Special cases**, checked in priority order:
1. Either operand is NaN: result `0x7FC00000`. NV is set if either NaN is signalling (exp = 255, frac ≠ 0, frac[22] = 0).
2. inf/inf or 0/0: result `0x7FC00000`, NV.
3. a = inf: result ±inf.
4. b = inf: result ±0.
5. b = 0 (a finite, nonzero): result ±inf, DZ.
6. a = 0: result ±0.

**DIV.** One restoring step per cycle:
- If `rem >= div`, then `rem -= div` and `q = {q, 1}`; else `q = {q, 0}`.
- Then `rem <<= 1` and `cnt++`.
- After the 26th step (`cnt == 25`), go to ROUND.

**ROUND.** Normalize, round and check range:
- If `q[25] = 1`: mant = `q[25:2]`, guard = `q[1]`, sticky = `q[0] | (rem != 0)`.
- Else: mant = `q[24:1]`, guard = `q[0]`, sticky = `(rem != 0)`, and `exp -= 1`.
- Round up when `guard & (sticky | mant[0])`. If the 24-bit mant carries out, set mant = `0x800000` and `exp += 1`.
- NX = `guard | sticky`.
- If `exp >= 255`: result ±inf, with OF and NX set.
- If `exp <= 0`: result ±0, with UF and NX set.
- Otherwise: result `{sign, exp[7:0], mant[22:0]}`.
- Go to DONE.

**DONE.**
- `done = 1`. `result` and `fflags` are held stable.
- If `advance` is high, go to IDLE. Otherwise stay in DONE.

**General rules.**
- `op_a`/`op_b` are sampled only in IDLE. Operand changes during DIV, ROUND or DONE are ignored.
- `start` dropping during DIV or ROUND cannot happen in correct use, because the pipeline is frozen by `busy`. If it does happen, the operation completes anyway and waits in DONE.
- Interrupt, branch or MRET flushes of EX are held off while `busy` is high. The divide always completes before any flush.

## Timing
- Reset values: state IDLE; `done` 0, `result` 0, `fflags` 0, `rem`/`div`/`q`/`cnt`/`exp` all 0.
- Reset asserted mid-operation aborts immediately. The divider returns to IDLE and discards the operation.
- Latency, with `start` first seen in IDLE at cycle 0:
  - Special case: `done` in cycle 1.
  - Normal case: DIV in cycles 1–26, ROUND in cycle 27, `done` in cycle 28.
- `busy` is high in cycles 0 through 27 and low in cycle 28. The pipeline advances at the end of cycle 28 unless IM/DM stalls hold it.
- The result is consumed in the cycle where `done & advance`. State is IDLE the next cycle.
- Back-to-back: if the next EX instruction is also `FDIV.S`, `start` is seen in IDLE one cycle after the advance.

## Test plan
- **Exact divide.** Start `a=0x40C00000` (6.0), `b=0x40000000` (2.0), `advance=1`.
  - `result=0x40400000`, `fflags=0x00`.
  - `done` high in cycle 28. `busy` high in cycles 0–27.
- **Inexact divide.** `a=0x3F800000` (1.0), `b=0x40400000` (3.0).
  - `result=0x3EAAAAAB`, `fflags=0x01`.
- **Special cases, each with `done` in cycle 1:**
  - `a=0x3F800000`, `b=0x00000000` → `0x7F800000`, `fflags=0x08`.
  - `a=0`, `b=0` → `0x7FC00000`, `fflags=0x10`.
  - `a=0x7F800001` (sNaN) → `0x7FC00000`, `fflags=0x10`.
- **Overflow.** `a=0x7F7FFFFF`, `b=0x3F000000` (0.5) → `0x7F800000`, `fflags=0x05`.
- **Underflow.** `a=0x00800000`, `b=0x40000000` → `0x00000000`, `fflags=0x03`.
- **Hold and back-to-back.** Hold `advance=0` for 3 cycles after `done`, then assert it.
  - `result`/`done` stay stable while `advance` is low.
  - A new start (6.0/2.0) begins one cycle after the advance and gives `done` 28 cycles later.
- **Reset mid-operation.** Assert `rst` in cycle 10 of a divide.
  - `done`/`result`/`fflags` read 0 immediately.
  - After release, a new divide completes with the correct value.
